// File: rtl/dac_spi_frame_writer.sv
// dac_spi_frame_writer: serialises one 12-bit DAC sample into a
// 32-bit LTC2624-style SPI write frame on the shared board bus.
module dac_spi_frame_writer #(
  parameter int unsigned CLK_DIV = 4,
  parameter logic [3:0]  CMD     = 4'b0011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [11:0] datain,
  input  logic [3:0]  address,
  output logic        busy,
  output logic        done,
  output logic        spi_mosi,
  output logic        spi_sck,
  output logic        dac_cs,
  output logic        dac_clr,
  output logic        amp_cs,
  output logic        ad_conv
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    DONE
  } state_t;

  localparam logic [7:0] LP_HALF_LAST = 8'(CLK_DIV - 1);

  state_t      r_state;
  logic [31:0] r_shift;
  logic [7:0]  r_half;
  logic [5:0]  r_bit;
  logic        r_sck;
  logic        r_cs;
  logic        r_busy;
  logic        r_done;
  logic        r_clr;
  logic [31:0] w_frame;

  assign w_frame = {8'h00, CMD, address, datain, 4'h0};

  // MOSI is the shift register MSB; clearing it outside SHIFT keeps MOSI low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_half  <= '0;
      r_bit   <= '0;
      r_sck   <= 1'b0;
      r_cs    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_busy <= 1'b0;
          if (start) begin
            r_shift <= w_frame;
            r_half  <= '0;
            r_bit   <= '0;
            r_sck   <= 1'b0;
            r_cs    <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (r_half == LP_HALF_LAST) begin
            r_half <= '0;
            r_sck  <= ~r_sck;
            if (r_sck) begin
              if (r_bit == 6'd31) begin
                r_shift <= '0;
                r_state <= HOLD;
              end else begin
                r_bit   <= r_bit + 6'd1;
                r_shift <= {r_shift[30:0], 1'b0};
              end
            end
          end else begin
            r_half <= r_half + 8'd1;
          end
        end
        HOLD: begin
          if (r_half == LP_HALF_LAST) begin
            r_half  <= '0;
            r_cs    <= 1'b1;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_half <= r_half + 8'd1;
          end
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_clr <= 1'b0;
    else     r_clr <= 1'b1;
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign spi_mosi = r_shift[31];
  assign spi_sck  = r_sck;
  assign dac_cs   = r_cs;
  assign dac_clr  = r_clr;
  assign amp_cs   = 1'b1;
  assign ad_conv  = 1'b0;

endmodule

// File: tb/tb_dac_spi_frame_writer.sv
// Bench for dac_spi_frame_writer: directed plus random frames,
// decoded from the SPI pins and compared with an arithmetic frame model.
module tb_dac_spi_frame_writer;

  localparam int CD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [11:0] datain = '0;
  logic [3:0]  address = '0;
  logic        busy, done, spi_mosi, spi_sck;
  logic        dac_cs, dac_clr, amp_cs, ad_conv;

  dac_spi_frame_writer #(.CLK_DIV(CD), .CMD(4'b0011)) dut (
    .clk(clk), .rst(rst), .start(start),
    .datain(datain), .address(address),
    .busy(busy), .done(done),
    .spi_mosi(spi_mosi), .spi_sck(spi_sck),
    .dac_cs(dac_cs), .dac_clr(dac_clr),
    .amp_cs(amp_cs), .ad_conv(ad_conv)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [31:0] cap;
  int rises, lowcnt;
  int done_cnt = 0, done_cyc = 0;
  int hi_run = 0, last_gap = 0;
  int mosi_bad = 0, const_bad = 0;
  logic [31:0] fq[$];
  int rq[$];
  int lq[$];
  int checks = 0, passes = 0;

  always @(negedge dac_cs) begin
    cap = '0;
    rises = 0;
    lowcnt = 0;
  end

  always @(posedge spi_sck) begin
    cap = {cap[30:0], spi_mosi};
    rises++;
  end

  always @(posedge dac_cs) begin
    fq.push_back(cap);
    rq.push_back(rises);
    lq.push_back(lowcnt);
  end

  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (dac_cs === 1'b0) lowcnt++;
    if (dac_cs === 1'b1 && spi_mosi !== 1'b0) mosi_bad++;
    if (amp_cs !== 1'b1 || ad_conv !== 1'b0) const_bad++;
    if (dac_cs === 1'b1) hi_run++;
    else if (hi_run > 0) begin
      last_gap = hi_run;
      hi_run = 0;
    end
  end

  function automatic logic [31:0] model(input logic [3:0] a,
                                        input logic [11:0] d);
    return 32'h0030_0000 + (32'(a) * 32'h1_0000) + (32'(d) * 32'd16);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_done(input int n);
    int k = 0;
    while (done_cnt < n && k < 3000) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("done_wait", 32'(done_cnt >= n), 32'd1);
  endtask

  task automatic clear_log();
    fq.delete();
    rq.delete();
    lq.delete();
    done_cnt = 0;
  endtask

  task automatic one_frame(input logic [3:0] a, input logic [11:0] d,
                           input string tag);
    clear_log();
    @(posedge clk);
    #1;
    address = a;
    datain = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(1);
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_frame"}, fq.size() > 0 ? fq[0] : 32'hx, model(a, d));
    chk({tag, "_rises"}, rq.size() > 0 ? 32'(rq[0]) : 32'hx, 32'd32);
    chk({tag, "_dones"}, 32'(done_cnt), 32'd1);
  endtask

  int e0, snap;
  logic [3:0] ra;
  logic [11:0] rd, d1, d2;

  initial begin
    #1 rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_clr", 32'(dac_clr), 32'd0);
    chk("rst_cs", 32'(dac_cs), 32'd1);
    chk("rst_sck", 32'(spi_sck), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mosi", 32'(spi_mosi), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("clr_before_edge", 32'(dac_clr), 32'd0);
    @(posedge clk);
    #1;
    chk("clr_after_edge", 32'(dac_clr), 32'd1);
    clear_log();

    // directed frame with a mid-frame data change and an ignored start
    @(posedge clk);
    #1;
    e0 = cyc;
    datain = 12'hA5C;
    address = 4'h0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("e1_busy", 32'(busy), 32'd1);
    chk("e1_cs", 32'(dac_cs), 32'd0);
    chk("e1_mosi", 32'(spi_mosi), 32'd0);
    repeat (CD - 1) @(posedge clk);
    #1;
    chk("sck_low_phase", 32'(spi_sck), 32'd0);
    @(posedge clk);
    #1;
    chk("sck_first_rise", 32'(spi_sck), 32'd1);
    repeat (40 - (CD + 1)) @(posedge clk);
    #1;
    datain = 12'hFFF;
    repeat (60) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(1);
    chk("done_time", 32'(done_cyc - e0), 32'(1 + 65 * CD));
    repeat (2 * 65 * CD) @(posedge clk);
    #1;
    chk("f1_frame", fq.size() > 0 ? fq[0] : 32'hx, 32'h0030A5C0);
    chk("f1_rises", rq.size() > 0 ? 32'(rq[0]) : 32'hx, 32'd32);
    chk("f1_cs_low", lq.size() > 0 ? 32'(lq[0]) : 32'hx, 32'(65 * CD));
    chk("f1_frames", 32'(fq.size()), 32'd1);
    chk("f1_dones", 32'(done_cnt), 32'd1);
    chk("f1_busy_end", 32'(busy), 32'd0);

    // back-to-back with start held high
    clear_log();
    d1 = 12'($urandom);
    d2 = 12'($urandom);
    @(posedge clk);
    #1;
    address = 4'h1;
    datain = d1;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    address = 4'hF;
    datain = d2;
    wait_done(2);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("b2b_f0", fq.size() > 0 ? fq[0] : 32'hx, model(4'h1, d1));
    chk("b2b_f1", fq.size() > 1 ? fq[1] : 32'hx, model(4'hF, d2));
    chk("b2b_frames", 32'(fq.size()), 32'd2);
    chk("b2b_dones", 32'(done_cnt), 32'd2);
    // DONE cycle plus the single IDLE cycle
    chk("b2b_cs_gap", 32'(last_gap), 32'd2);

    for (int i = 0; i < 3; i++) begin
      ra = 4'($urandom);
      rd = 12'($urandom_range(0, 4095));
      one_frame(ra, rd, "rand");
    end

    // reset in the middle of a frame
    clear_log();
    @(posedge clk);
    #1;
    e0 = cyc;
    address = 4'h7;
    datain = 12'h123;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (149) @(posedge clk);
    #2;
    snap = done_cnt;
    chk("mid_cs_low", 32'(dac_cs), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_cs", 32'(dac_cs), 32'd1);
    chk("mid_rst_sck", 32'(spi_sck), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_clr", 32'(dac_clr), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    chk("mid_no_done", 32'(done_cnt), 32'(snap));
    ra = 4'($urandom);
    rd = 12'($urandom);
    one_frame(ra, rd, "post_rst");

    chk("mosi_idle_low", 32'(mosi_bad), 32'd0);
    chk("amp_adc_const", 32'(const_bad), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
